// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder stage: operand width and front-end FSM states.
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH = 4;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } sa_state_e;

    localparam logic [0:0] ST_IDLE    = IDLE;
    localparam logic [0:0] ST_COLLECT = COLLECT;

endpackage

// File: rtl/bit_shift_in.sv
// Right-shifting serial-in register: new bit enters at MSB, so after WIDTH shifts bit 0 sits at LSB.
module bit_shift_in
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-2:0] keep_c;

    // A clear together with a shift starts a fresh word with bit_in as its first bit.
    assign keep_c = clr ? '0 : q[WIDTH-1:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {bit_in, keep_c};
        end else if (clr) begin
            q <= '0;
        end
    end

endmodule

// File: rtl/serial_operand_deser.sv
// Bit-serial front end of the adder stage: collects a/b LSB first and presents
// them as parallel words through a double-buffered valid/ready output.
module serial_operand_deser
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a_bit,
    input  logic             in_b_bit,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             frame_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             out_valid_d;
    logic             frame_err_d;
    logic [WIDTH-1:0] a_out_d;
    logic [WIDTH-1:0] b_out_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic acc_c;
    logic last_c;
    logic collect_c;
    logic shift_en_c;
    logic clr_c;
    logic unused_c;

    assign collect_c = (state_q == ST_COLLECT);
    assign last_c    = (cnt_q == CNT_LAST);

    // Only the completing bit stalls, and only while the held word is not being taken.
    assign in_ready  = ~(out_valid & ~out_ready & collect_c & last_c);
    assign acc_c     = in_valid & in_ready;

    assign shift_en_c = acc_c & (collect_c | in_sof);
    assign clr_c      = acc_c & in_sof;

    // The register LSB is never part of a completed word: the final bit is merged in directly.
    assign unused_c = ^{a_q[0], b_q[0]};

    bit_shift_in #(.WIDTH(WIDTH)) u_shift_a (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_c),
        .clr      (clr_c),
        .bit_in   (in_a_bit),
        .q        (a_q)
    );

    bit_shift_in #(.WIDTH(WIDTH)) u_shift_b (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_c),
        .clr      (clr_c),
        .bit_in   (in_b_bit),
        .q        (b_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_valid <= out_valid_d;
            frame_err <= frame_err_d;
            a_out     <= a_out_d;
            b_out     <= b_out_d;
        end
    end

    // Next-state: collect FSM, bit counter and output buffer handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid;
        frame_err_d = 1'b0;
        a_out_d     = a_out;
        b_out_d     = b_out;

        if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (acc_c && in_sof) begin
                state_d = ST_COLLECT;
                cnt_d   = CNT_ONE;
            end
        end else if (acc_c) begin
            if (in_sof) begin
                cnt_d       = CNT_ONE;
                frame_err_d = (cnt_q != '0);
            end else if (last_c) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                a_out_d     = {in_a_bit, a_q[WIDTH-1:1]};
                b_out_d     = {in_b_bit, b_q[WIDTH-1:1]};
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_serial_operand_deser.sv
// Scoreboard bench for serial_operand_deser: directed words, backpressure, early SOF and reset.
module tb_serial_operand_deser;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_a_bit;
    logic       in_b_bit;
    logic       in_sof;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic       frame_err;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   fe_seen;

    serial_operand_deser #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a_bit  (in_a_bit),
        .in_b_bit  (in_b_bit),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one bit pair from a falling edge and returns on the falling edge after it is accepted.
    task automatic send_bit(input logic a, input logic b, input logic sof);
        int n;
        in_valid = 1'b1;
        in_a_bit = a;
        in_b_bit = b;
        in_sof   = sof;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            send_bit(a[i], b[i], i == 0);
        end
    endtask

    // Output monitor: a handshake happens on the coming rising edge when valid and ready are both high.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_word: got a=%0h b=%0h expected none", a_out, b_out);
            end else begin
                e = exp_q.pop_front();
                check("word_a", 32'(a_out), 32'(e.a));
                check("word_b", 32'(b_out), 32'(e.b));
            end
        end
        if (frame_err) fe_seen++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        fe_seen   = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a_bit  = 1'b0;
        in_b_bit  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_a_out", 32'(a_out), 32'h0);
        check("rst_b_out", 32'(b_out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // Single word: a = 1,0,1,1 / b = 0,1,1,0 LSB first.
        exp_q.push_back('{a: 4'b1101, b: 4'b0110});
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        check("single_valid_drop", 32'(out_valid), 32'h0);

        // Backpressure: word 1 held, word 2 stalls only on its last bit.
        out_ready = 1'b0;
        exp_q.push_back('{a: 4'h3, b: 4'h5});
        send_word(4'h3, 4'h5);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_a_bit = 1'b1;
        in_b_bit = 1'b1;
        in_sof   = 1'b0;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'h0);
        @(negedge clk);
        #1;
        check("bp_in_ready_held", 32'(in_ready), 32'h0);
        check("bp_word1_held", 32'(out_valid), 32'h1);
        exp_q.push_back('{a: 4'hA, b: 4'hC});
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_word2_valid", 32'(out_valid), 32'h1);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'h0);

        // Back-to-back words with no gap.
        exp_q.push_back('{a: 4'hF, b: 4'h1});
        exp_q.push_back('{a: 4'h0, b: 4'hE});
        send_word(4'hF, 4'h1);
        check("b2b_valid1", 32'(out_valid), 32'h1);
        send_bit(1'b0, 1'b0, 1'b1);
        check("b2b_consumed1", 32'(out_valid), 32'h0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        check("b2b_valid2", 32'(out_valid), 32'h1);
        @(negedge clk);

        // Early SOF: two-bit partial frame, then a = 9, b = 6.
        exp_q.push_back('{a: 4'h9, b: 4'h6});
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        check("esof_no_word", 32'(out_valid), 32'h0);
        send_bit(1'b1, 1'b0, 1'b1);
        check("esof_frame_err", 32'(frame_err), 32'h1);
        send_bit(1'b0, 1'b1, 1'b0);
        check("esof_frame_err_pulse", 32'(frame_err), 32'h0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("esof_valid", 32'(out_valid), 32'h1);
        @(negedge clk);

        // Bits without SOF from IDLE are dropped.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check("nosof_out_valid", 32'(out_valid), 32'h0);
        check("nosof_in_ready", 32'(in_ready), 32'h1);

        // Reset with a pending word and a partial frame.
        out_ready = 1'b0;
        send_word(4'h5, 4'hA);
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        check("mid_pending", 32'(out_valid), 32'h1);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_a_out", 32'(a_out), 32'h0);
        check("mid_rst_b_out", 32'(b_out), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_frame_err", 32'(frame_err), 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h1);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.push_back('{a: 4'h6, b: 4'h9});
        send_word(4'h6, 4'h9);
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'h1);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        check("frame_err_count", 32'(fe_seen), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_operand_deser.md
# serial_operand_deser

Bit-serial operand front end for the 4-bit adder stage. It receives the two addend operands `a` and `b` one bit per cycle, LSB first, over a valid/ready stream. It assembles them into parallel words and presents them, double-buffered, with a valid/ready handshake. Its `a_out`/`b_out` drive the adder's `a`/`b` inputs directly.

## Interface
- `WIDTH`, 4: operand width in bits; must be ≥ 2.
- `CNT_W`, $clog2(WIDTH): width of the bit counter.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock domain.
- `in_valid`  in  1  `in_a_bit`/`in_b_bit`/`in_sof` valid this cycle.
- `in_ready`  out  1  block accepts a bit pair this cycle.
- `in_a_bit`  in  1  next bit of operand a, LSB first.
- `in_b_bit`  in  1  next bit of operand b, LSB first.
- `in_sof`  in  1  start of frame: this bit pair is bit 0 of a new word.
- `out_valid`  out  1  `a_out`/`b_out` hold a complete word.
- `out_ready`  in  1  downstream consumes the word.
- `a_out`  out  WIDTH  assembled operand a.
- `b_out`  out  WIDTH  assembled operand b.
- `frame_err`  out  1  one-cycle pulse: partial word discarded by early `in_sof`.

## Operation
- Bit accept: `acc = in_valid & in_ready`.
- Collect stage:
  - Two WIDTH-bit shift registers, right-shifting. The new bit enters at MSB, so after WIDTH accepts bit 0 sits at LSB.
  - Bit counter `cnt` runs 0..WIDTH-1.
- FSM (collect side), two states:
  - IDLE: `cnt` = 0, no partial word.
    - `acc` with `in_sof` = 1 → COLLECT, `cnt` = 1.
    - `acc` with `in_sof` = 0: the bit is dropped and the state stays IDLE. Frames must start with `in_sof`.
  - COLLECT: `acc` increments `cnt`.
    - On the accept with `cnt` = WIDTH-1 (the final bit), the full word including that bit is copied into `a_out`/`b_out`, `out_valid` ← 1, `cnt` ← 0, state → IDLE.
- Early SOF: `acc` with `in_sof` = 1 while in COLLECT and `cnt` ≠ 0:
  - The partial word is discarded and `frame_err` pulses for one cycle.
  - The bit is taken as bit 0 of a new word (`cnt` ← 1, state stays COLLECT).
- Output stage:
  - `out_valid` stays high and `a_out`/`b_out` stay stable until `out_valid & out_ready`.
  - On that handshake `out_valid` ← 0, unless a new word completes the same cycle.
  - If a new word completes the same cycle, the output registers load the new word and `out_valid` stays 1. No bubble.
- Backpressure: `in_ready = ~(out_valid & ~out_ready & (state == COLLECT) & (cnt == WIDTH-1))`.
  - Only the completing bit stalls. Bits 0..WIDTH-2 of the next word are accepted while the output is held.
- Reset (asynchronous assert, synchronous release):
  - state IDLE, `cnt` 0, shift registers 0.
  - `a_out` 0, `b_out` 0, `out_valid` 0, `frame_err` 0.
  - `in_ready` = 1 while reset is released.
- Reset mid-frame: the partial word and any pending output word are lost. No `frame_err` is raised.

## Timing
- Latency: the final bit is accepted at edge N; `out_valid` and the new `a_out`/`b_out` are visible after edge N.
- Sustained throughput: one word per WIDTH cycles with `out_ready` held at 1.
- `frame_err` is asserted for exactly the cycle after the offending `in_sof` accept.
- `in_ready` is combinational from `out_ready`, `out_valid`, state and `cnt`. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Package `serial_adder_pkg`:
  - `SA_WIDTH` = 4 (shared with the adder stage).
  - FSM state typedef {IDLE, COLLECT}.
- Sub-module `bit_shift_in` (WIDTH parameter; ports: clk, reset, shift_en, clr, bit_in, q). Instantiated twice, for operand a and operand b.
- FSM, counter, output registers and handshake logic live in the top.

## Test plan
- Single word, `out_ready` = 1: SOF + bits a = 1,0,1,1 / b = 0,1,1,0 over 4 cycles → `a_out` = 4'b1101, `b_out` = 4'b0110, `out_valid` high for 1 cycle after the last bit.
- Backpressure:
  - `out_ready` = 0 holds word 1 (a = 4'h3, b = 4'h5). Word 2 bits 0..2 are accepted and `in_ready` drops at bit 3.
  - Raising `out_ready` → word 1 consumed, word 2 (a = 4'hA, b = 4'hC) loads next cycle.
- Back-to-back with `out_ready` = 1: words (4'hF,4'h1) then (4'h0,4'hE) with no gap → `out_valid` at cycles 4 and 8, each value correct.
- Early SOF: SOF + 2 bits, then SOF + 4 bits of a = 4'h9, b = 4'h6 → `frame_err` pulses once, output 9/6, no spurious word.
- Bits without SOF from IDLE: 3 bit pairs with `in_sof` = 0 → dropped, `out_valid` stays 0, `in_ready` = 1.
- Reset asserted after 2 bits while a word is pending output → all outputs 0 immediately (asynchronous). After release a fresh SOF word completes correctly.
